quadrilatero_mrf_port: RTL

QUADRILATERO_MRF_PORT -- requirements
Module: quadrilatero_mrf_port

---
 rtl/quadrilatero_pkg.sv | 20 ++
 rtl/quadrilatero_mrf_scoreboard.sv | 71 +++++++
 rtl/quadrilatero_mrf_port.sv | 130 +++++++++++++
 3 files changed

// File: rtl/quadrilatero_pkg.sv
// Shared types and sizing helpers for the quadrilatero matrix register file port.
package quadrilatero_pkg;

    typedef enum logic {RD_IDLE, RD_STREAM} rd_state_e;

    localparam int unsigned DEF_N_REGS     = 8;
    localparam int unsigned DEF_MESH_WIDTH = 4;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    function automatic int unsigned rlen_f(input int unsigned data_width,
                                           input int unsigned mesh_width);
        return data_width * mesh_width;
    endfunction

    // Index width that stays legal for single-entry dimensions.
    function automatic int unsigned idx_w_f(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/quadrilatero_mrf_scoreboard.sv
// Per-register busy tracking (RAW) and read-vs-write register compare (WAR).
// QUADRILATERO_MRF_BYPASS_EN narrows the RAW stall to rows not yet written in the burst.
module quadrilatero_mrf_scoreboard
    import quadrilatero_pkg::*;
#(
    parameter int unsigned N_REGS = DEF_N_REGS,
    parameter int unsigned N_ROWS = DEF_MESH_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         we_acc_i,
    input  logic [idx_w_f(N_REGS)-1:0]   waddr_i,
    input  logic [idx_w_f(N_ROWS)-1:0]   wrowaddr_i,
    input  logic                         wlast_i,
    input  logic [idx_w_f(N_REGS)-1:0]   chk_reg_i,
    input  logic [idx_w_f(N_ROWS)-1:0]   chk_row_i,
    input  logic                         streaming_i,
    input  logic [idx_w_f(N_REGS)-1:0]   lookup_reg_i,
    input  logic [idx_w_f(N_ROWS)-1:0]   lookup_row_i,
    output logic                         hazard_o,
    output logic                         war_o
);

    localparam int unsigned ROW_W = idx_w_f(N_ROWS);

    logic [N_REGS-1:0] busy_q, busy_d;

    // Clear takes priority so a set and clear in one cycle resolve to clear.
    always_comb begin
        busy_d = busy_q;
        if (we_acc_i) begin
            if (wlast_i) begin
                busy_d[waddr_i] = 1'b0;
            end else if (wrowaddr_i == '0) begin
                busy_d[waddr_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

`ifdef QUADRILATERO_MRF_BYPASS_EN
    // Next row still to be written per register during a burst.
    logic [ROW_W:0] wptr_q [N_REGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(N_REGS); i++) begin
                wptr_q[i] <= '0;
            end
        end else if (we_acc_i && !wlast_i) begin
            wptr_q[waddr_i] <= {1'b0, wrowaddr_i} + (ROW_W + 1)'(1);
        end
    end

    assign hazard_o = busy_q[chk_reg_i] && ({1'b0, chk_row_i} >= wptr_q[chk_reg_i]);
`else
    logic unused_chk_row;
    assign unused_chk_row = ^chk_row_i;
    assign hazard_o       = busy_q[chk_reg_i];
`endif

    assign war_o = streaming_i && (waddr_i == lookup_reg_i) && (lookup_row_i != '0);

endmodule

// File: rtl/quadrilatero_mrf_port.sv
// Matrix register file port: row-streaming read pipeline plus row write port with hazard checks.
// Define QUADRILATERO_MRF_BYPASS_EN to forward same-cycle writes into the read lookup.
module quadrilatero_mrf_port
    import quadrilatero_pkg::*;
#(
    parameter int unsigned N_REGS     = DEF_N_REGS,
    parameter int unsigned MESH_WIDTH = DEF_MESH_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [idx_w_f(N_REGS)-1:0]                 raddr_i,
    input  logic [idx_w_f(MESH_WIDTH)-1:0]             rrowaddr_i,
    input  logic                                       rdata_ready_i,
    input  logic                                       rlast_i,
    output logic [rlen_f(DATA_WIDTH, MESH_WIDTH)-1:0]  rdata_o,
    output logic                                       rdata_valid_o,
    input  logic [idx_w_f(N_REGS)-1:0]                 waddr_i,
    input  logic [idx_w_f(MESH_WIDTH)-1:0]             wrowaddr_i,
    input  logic [rlen_f(DATA_WIDTH, MESH_WIDTH)-1:0]  wdata_i,
    input  logic                                       we_i,
    input  logic                                       wlast_i,
    output logic                                       wready_o
);

    localparam int unsigned N_ROWS = MESH_WIDTH;
    localparam int unsigned RLEN   = rlen_f(DATA_WIDTH, MESH_WIDTH);
    localparam int unsigned REG_W  = idx_w_f(N_REGS);
    localparam int unsigned ROW_W  = idx_w_f(N_ROWS);

    logic [RLEN-1:0]  mem_q [N_REGS][N_ROWS];
    logic [RLEN-1:0]  rdata_q;
    rd_state_e        state_q, state_d;
    logic [REG_W-1:0] lookup_reg_q, lookup_reg_d, chk_reg;
    logic [ROW_W-1:0] lookup_row_q, lookup_row_d, chk_row;
    logic             streaming, addr_match, hazard, war, we_acc, valid;

    assign streaming  = (state_q == RD_STREAM);
    assign addr_match = (raddr_i == lookup_reg_q) && (rrowaddr_i == lookup_row_q);
    assign chk_reg    = streaming ? lookup_reg_q : raddr_i;
    assign chk_row    = streaming ? lookup_row_q : rrowaddr_i;
    assign wready_o   = !rst_i && !war;
    assign we_acc     = we_i && wready_o;

    quadrilatero_mrf_scoreboard #(
        .N_REGS (N_REGS),
        .N_ROWS (N_ROWS)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .we_acc_i     (we_acc),
        .waddr_i      (waddr_i),
        .wrowaddr_i   (wrowaddr_i),
        .wlast_i      (wlast_i),
        .chk_reg_i    (chk_reg),
        .chk_row_i    (chk_row),
        .streaming_i  (streaming),
        .lookup_reg_i (lookup_reg_q),
        .lookup_row_i (lookup_row_q),
        .hazard_o     (hazard),
        .war_o        (war)
    );

    always_comb begin
        state_d      = state_q;
        lookup_reg_d = lookup_reg_q;
        lookup_row_d = lookup_row_q;
        valid        = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                if (rdata_ready_i && !hazard) begin
                    lookup_reg_d = raddr_i;
                    lookup_row_d = rrowaddr_i;
                    state_d      = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (rdata_ready_i) begin
                    if (!addr_match) begin
                        lookup_reg_d = raddr_i;
                        lookup_row_d = rrowaddr_i;
                    end else if (!hazard) begin
                        valid = 1'b1;
                        if (rlast_i) begin
                            state_d = RD_IDLE;
                        end else if (lookup_row_q != ROW_W'(N_ROWS - 1)) begin
                            lookup_row_d = lookup_row_q + ROW_W'(1);
                        end
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

`ifdef QUADRILATERO_MRF_BYPASS_EN
    logic fwd;
    assign fwd = we_acc && (waddr_i == lookup_reg_d) && (wrowaddr_i == lookup_row_d);
`endif

    // rdata_q always tracks the row the next cycle will look up.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RD_IDLE;
            lookup_reg_q <= '0;
            lookup_row_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            lookup_reg_q <= lookup_reg_d;
            lookup_row_q <= lookup_row_d;
            rdata_q      <= mem_q[lookup_reg_d][lookup_row_d];
`ifdef QUADRILATERO_MRF_BYPASS_EN
            if (fwd) begin
                rdata_q <= wdata_i;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_acc) begin
            mem_q[waddr_i][wrowaddr_i] <= wdata_i;
        end
    end

    assign rdata_valid_o = valid && !rst_i;
    assign rdata_o       = rst_i ? '0 : rdata_q;

endmodule
